// File: rtl/axis_pkt_rr_arbiter.sv
// rtl/axis_pkt_rr_arbiter.sv - packet-level round-robin AXI4-Stream arbiter, N sources to one master
// Optional AXIS_ARB_SRCID_EN adds m_axis_tid carrying the granted source index.
module axis_pkt_rr_arbiter #(
  parameter int N_SRC   = 2,
  parameter int TDATA_W = 512,
  parameter int GRANT_W = 3,
  parameter int CNT_W   = 32
) (
  input  logic                       aclk,
  input  logic                       aresetn,
  input  logic [N_SRC-1:0]           s_axis_tvalid,
  output logic [N_SRC-1:0]           s_axis_tready,
  input  logic [N_SRC*TDATA_W-1:0]   s_axis_tdata,
  input  logic [N_SRC*TDATA_W/8-1:0] s_axis_tkeep,
  input  logic [N_SRC-1:0]           s_axis_tlast,
  output logic                       m_axis_tvalid,
  input  logic                       m_axis_tready,
  output logic [TDATA_W-1:0]         m_axis_tdata,
  output logic [TDATA_W/8-1:0]       m_axis_tkeep,
  output logic                       m_axis_tlast,
`ifdef AXIS_ARB_SRCID_EN
  output logic [GRANT_W-1:0]         m_axis_tid,
`endif
  output logic [GRANT_W-1:0]         grant_idx,
  output logic                       busy,
  output logic [CNT_W-1:0]           pkt_cnt
);

  localparam int KEEP_W = TDATA_W / 8;
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_XFER = 1'b1;

  logic [0:0]         state_q, state_d;
  logic [GRANT_W-1:0] grant_q, grant_d;
  logic [GRANT_W-1:0] last_grant_q, last_grant_d;
  logic [CNT_W-1:0]   pkt_cnt_q, pkt_cnt_d;
  logic [GRANT_W-1:0] rr_pick;
  logic               rr_any;

  // Walk offsets from farthest to nearest so the nearest requester after last_grant wins.
  always_comb begin
    rr_pick = '0;
    rr_any  = |s_axis_tvalid;
    for (int k = N_SRC; k >= 1; k--) begin
      for (int j = 0; j < N_SRC; j++) begin
        if (s_axis_tvalid[j] && (j == ((int'(last_grant_q) + k) % N_SRC))) begin
          rr_pick = GRANT_W'(j);
        end
      end
    end
  end

  always_comb begin
    m_axis_tvalid = 1'b0;
    m_axis_tdata  = '0;
    m_axis_tkeep  = '0;
    m_axis_tlast  = 1'b0;
    s_axis_tready = '0;
    for (int j = 0; j < N_SRC; j++) begin
      if ((state_q == ST_XFER) && (grant_q == GRANT_W'(j))) begin
        m_axis_tvalid    = s_axis_tvalid[j];
        m_axis_tdata     = s_axis_tdata[j*TDATA_W +: TDATA_W];
        m_axis_tkeep     = s_axis_tkeep[j*KEEP_W +: KEEP_W];
        m_axis_tlast     = s_axis_tlast[j];
        s_axis_tready[j] = m_axis_tready;
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    pkt_cnt_d    = pkt_cnt_q;
    if (state_q == ST_IDLE) begin
      if (rr_any) begin
        grant_d = rr_pick;
        state_d = ST_XFER;
      end
    end else if (m_axis_tvalid && m_axis_tready && m_axis_tlast) begin
      last_grant_d = grant_q;
      pkt_cnt_d    = pkt_cnt_q + 1'b1;
      state_d      = ST_IDLE;
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q      <= ST_IDLE;
      grant_q      <= '0;
      last_grant_q <= GRANT_W'(N_SRC - 1);
      pkt_cnt_q    <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      pkt_cnt_q    <= pkt_cnt_d;
    end
  end

  assign grant_idx = grant_q;
  assign busy      = (state_q == ST_XFER);
  assign pkt_cnt   = pkt_cnt_q;
`ifdef AXIS_ARB_SRCID_EN
  assign m_axis_tid = busy ? grant_q : '0;
`endif

endmodule

// File: tb/tb_axis_pkt_rr_arbiter.sv
// tb/tb_axis_pkt_rr_arbiter.sv - directed self-checking bench for axis_pkt_rr_arbiter
// Beat tdata layout: [7:0] byte0, [15:8] source, [23:16] beat index, [31:24] packet index.
module tb_axis_pkt_rr_arbiter;

  logic          aclk = 1'b0;
  logic          aresetn = 1'b0;
  logic [1:0]    s_tvalid, s_tready, s_tlast;
  logic [1023:0] s_tdata;
  logic [127:0]  s_tkeep;
  logic          m_tvalid, m_tready, m_tlast;
  logic [511:0]  m_tdata;
  logic [63:0]   m_tkeep;
  logic [2:0]    grant_idx;
  logic          busy;
  logic [31:0]   pkt_cnt;
`ifdef AXIS_ARB_SRCID_EN
  logic [2:0]    m_tid;
`endif

  logic          src_valid [2];
  logic          src_last  [2];
  logic [511:0]  src_data  [2];
  logic [63:0]   src_keep  [2];

  assign s_tvalid = {src_valid[1], src_valid[0]};
  assign s_tlast  = {src_last[1], src_last[0]};
  assign s_tdata  = {src_data[1], src_data[0]};
  assign s_tkeep  = {src_keep[1], src_keep[0]};

  localparam logic [63:0] KEEP_LAST = 64'h0000_0000_0000_00FF;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic bp_done;

  typedef struct {
    int src; int b0; int beat; int pkt; bit last; logic [63:0] keep; int cyc; int tid;
  } beat_t;
  beat_t mon_q[$];

  axis_pkt_rr_arbiter #(.N_SRC(2), .TDATA_W(512), .GRANT_W(3), .CNT_W(32)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready), .s_axis_tdata(s_tdata),
    .s_axis_tkeep(s_tkeep), .s_axis_tlast(s_tlast),
    .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready), .m_axis_tdata(m_tdata),
    .m_axis_tkeep(m_tkeep), .m_axis_tlast(m_tlast),
`ifdef AXIS_ARB_SRCID_EN
    .m_axis_tid(m_tid),
`endif
    .grant_idx(grant_idx), .busy(busy), .pkt_cnt(pkt_cnt)
  );

  always #5 aclk = ~aclk;
  always @(posedge aclk) cyc <= cyc + 1;

  always @(negedge aclk) begin
    if (m_tvalid && m_tready) begin
`ifdef AXIS_ARB_SRCID_EN
      mon_q.push_back('{int'(m_tdata[15:8]), int'(m_tdata[7:0]), int'(m_tdata[23:16]),
                        int'(m_tdata[31:24]), m_tlast, m_tkeep, cyc, int'(m_tid)});
`else
      mon_q.push_back('{int'(m_tdata[15:8]), int'(m_tdata[7:0]), int'(m_tdata[23:16]),
                        int'(m_tdata[31:24]), m_tlast, m_tkeep, cyc, 0});
`endif
    end
  end

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge aclk);
    #1;
  endtask

  task automatic send_beat(input int src, input int b0, input int beat, input int pkt, input bit last);
    bit done;
    int n;
    done = 1'b0;
    n = 0;
    src_data[src] = '0;
    src_data[src][7:0]   = 8'(b0);
    src_data[src][15:8]  = 8'(src);
    src_data[src][23:16] = 8'(beat);
    src_data[src][31:24] = 8'(pkt);
    src_keep[src]  = last ? KEEP_LAST : '1;
    src_last[src]  = last;
    src_valid[src] = 1'b1;
    while (!done && n < 200) begin
      @(negedge aclk);
      if (s_tready[src]) done = 1'b1;
      @(posedge aclk);
      #1;
      n++;
    end
    src_valid[src] = 1'b0;
    src_last[src]  = 1'b0;
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL send_timeout src%0d pkt%0d beat%0d: not accepted within 200 cycles", src, pkt, beat);
    end
  endtask

  task automatic drive_pkts(input int src, input int npkts, input int nb);
    for (int p = 0; p < npkts; p++) begin
      for (int b = 0; b < nb; b++) begin
        send_beat(src, (b == nb - 1) ? 8'h9E : p + b, b, p, b == nb - 1);
      end
    end
  endtask

  task automatic test_reset;
    aresetn = 1'b0;
    src_valid[0] = 1'b1;
    src_valid[1] = 1'b1;
    wait_cycles(3);
    checks++; if (s_tready !== 2'b00) begin errors++; $display("FAIL reset_tready got %b want 00", s_tready); end
    checks++; if (m_tvalid !== 1'b0) begin errors++; $display("FAIL reset_tvalid got %b want 0", m_tvalid); end
    checks++; if (pkt_cnt !== 32'd0) begin errors++; $display("FAIL reset_pkt_cnt got %0d want 0", pkt_cnt); end
    checks++; if (grant_idx !== 3'd0) begin errors++; $display("FAIL reset_grant got %0d want 0", grant_idx); end
    checks++; if (busy !== 1'b0 || m_tdata !== '0 || m_tlast !== 1'b0) begin
      errors++; $display("FAIL reset_outputs busy=%b tlast=%b data_nonzero=%b want 0 0 0", busy, m_tlast, |m_tdata);
    end
`ifdef AXIS_ARB_SRCID_EN
    checks++; if (m_tid !== 3'd0) begin errors++; $display("FAIL reset_tid got %0d want 0", m_tid); end
`endif
    src_valid[0] = 1'b0;
    src_valid[1] = 1'b0;
    wait_cycles(1);
    aresetn = 1'b1;
    wait_cycles(1);
  endtask

  task automatic test_single_source;
    int base;
    base = mon_q.size();
    m_tready = 1'b1;
    drive_pkts(0, 12, 2);
    wait_cycles(3);
    checks++;
    if (mon_q.size() - base !== 24) begin
      errors++; $display("FAIL single_count got %0d want 24", mon_q.size() - base);
    end else begin
      for (int i = 0; i < 24; i++) begin
        checks++;
        if (mon_q[base+i].src !== 0 || mon_q[base+i].b0 !== ((i % 2 == 1) ? 8'h9E : i / 2) ||
            mon_q[base+i].last !== (i % 2 == 1) ||
            mon_q[base+i].keep !== ((i % 2 == 1) ? KEEP_LAST : 64'hFFFF_FFFF_FFFF_FFFF)) begin
          errors++;
          $display("FAIL single_beat%0d got src=%0d b0=%0h last=%0b keep=%h", i, mon_q[base+i].src,
                   mon_q[base+i].b0, mon_q[base+i].last, mon_q[base+i].keep);
        end
        if (i > 0) begin
          checks++;
          if (mon_q[base+i].cyc - mon_q[base+i-1].cyc !== ((i % 2 == 0) ? 2 : 1)) begin
            errors++;
            $display("FAIL single_spacing beat%0d got %0d cycles want %0d", i,
                     mon_q[base+i].cyc - mon_q[base+i-1].cyc, (i % 2 == 0) ? 2 : 1);
          end
        end
      end
    end
    checks++; if (pkt_cnt !== 32'd12) begin errors++; $display("FAIL single_pkt_cnt got %0d want 12", pkt_cnt); end
  endtask

  task automatic test_contention;
    int base;
    aresetn = 1'b0;
    wait_cycles(1);
    aresetn = 1'b1;
    wait_cycles(1);
    base = mon_q.size();
    fork
      drive_pkts(0, 3, 2);
      drive_pkts(1, 3, 2);
    join
    wait_cycles(3);
    checks++;
    if (mon_q.size() - base !== 12) begin
      errors++; $display("FAIL contention_count got %0d want 12", mon_q.size() - base);
    end else begin
      for (int i = 0; i < 12; i++) begin
        checks++;
        if (mon_q[base+i].src !== (i / 2) % 2 || mon_q[base+i].pkt !== i / 4 ||
            mon_q[base+i].beat !== i % 2) begin
          errors++;
          $display("FAIL contention_beat%0d got src=%0d pkt=%0d beat=%0d want %0d %0d %0d", i,
                   mon_q[base+i].src, mon_q[base+i].pkt, mon_q[base+i].beat, (i / 2) % 2, i / 4, i % 2);
        end
      end
    end
    checks++; if (pkt_cnt !== 32'd6) begin errors++; $display("FAIL contention_pkt_cnt got %0d want 6", pkt_cnt); end
  endtask

  task automatic test_backpressure;
    int base;
    base = mon_q.size();
    bp_done = 1'b0;
    fork
      begin
        drive_pkts(1, 1, 8);
        bp_done = 1'b1;
      end
      begin
        int c;
        c = 0;
        while (!bp_done && c < 400) begin
          m_tready = ((c % 8) >= 2);
          @(posedge aclk);
          #1;
          c++;
        end
        m_tready = 1'b1;
      end
      begin
        while (!bp_done) begin
          @(negedge aclk);
          if (busy) begin
            checks++;
            if (s_tready[1] !== m_tready || s_tready[0] !== 1'b0 || grant_idx !== 3'd1) begin
              errors++;
              $display("FAIL bp_tracking got tready=%b m_tready=%b grant=%0d want tready[1]=m_tready grant=1",
                       s_tready, m_tready, grant_idx);
            end
          end
        end
      end
    join
    wait_cycles(2);
    checks++;
    if (mon_q.size() - base !== 8) begin
      errors++; $display("FAIL bp_count got %0d want 8", mon_q.size() - base);
    end else begin
      for (int i = 0; i < 8; i++) begin
        checks++;
        if (mon_q[base+i].src !== 1 || mon_q[base+i].beat !== i || mon_q[base+i].last !== (i == 7)) begin
          errors++;
          $display("FAIL bp_beat%0d got src=%0d beat=%0d last=%0b", i, mon_q[base+i].src,
                   mon_q[base+i].beat, mon_q[base+i].last);
        end
      end
    end
    checks++; if (pkt_cnt !== 32'd7) begin errors++; $display("FAIL bp_pkt_cnt got %0d want 7", pkt_cnt); end
  endtask

  task automatic test_mid_reset;
    int base;
    m_tready = 1'b1;
    drive_pkts(0, 1, 1);
    send_beat(1, 0, 0, 0, 1'b0);
    src_data[1][7:0]   = 8'h9E;
    src_data[1][23:16] = 8'd1;
    src_keep[1]  = KEEP_LAST;
    src_last[1]  = 1'b1;
    src_valid[1] = 1'b1;
    #1;
    checks++; if (m_tvalid !== 1'b1 || busy !== 1'b1) begin
      errors++; $display("FAIL midrst_pre got tvalid=%b busy=%b want 1 1", m_tvalid, busy);
    end
    #1;
    aresetn = 1'b0;
    #1;
    checks++; if (m_tvalid !== 1'b0 || s_tready !== 2'b00 || busy !== 1'b0) begin
      errors++; $display("FAIL midrst_idle got tvalid=%b tready=%b busy=%b want 0 00 0", m_tvalid, s_tready, busy);
    end
    checks++; if (pkt_cnt !== 32'd0 || grant_idx !== 3'd0) begin
      errors++; $display("FAIL midrst_regs got pkt_cnt=%0d grant=%0d want 0 0", pkt_cnt, grant_idx);
    end
    src_valid[1] = 1'b0;
    src_last[1]  = 1'b0;
    wait_cycles(2);
    aresetn = 1'b1;
    wait_cycles(1);
    base = mon_q.size();
    fork
      drive_pkts(0, 1, 1);
      drive_pkts(1, 1, 1);
    join
    wait_cycles(2);
    checks++;
    if (mon_q.size() - base !== 2) begin
      errors++; $display("FAIL midrst_count got %0d want 2", mon_q.size() - base);
    end else if (mon_q[base].src !== 0 || mon_q[base+1].src !== 1) begin
      errors++; $display("FAIL midrst_order got %0d,%0d want 0,1", mon_q[base].src, mon_q[base+1].src);
    end
    checks++; if (pkt_cnt !== 32'd2) begin errors++; $display("FAIL midrst_pkt_cnt got %0d want 2", pkt_cnt); end
  endtask

`ifdef AXIS_ARB_SRCID_EN
  task automatic test_srcid;
    int base;
    base = mon_q.size();
    fork
      drive_pkts(0, 2, 2);
      drive_pkts(1, 2, 2);
    join
    wait_cycles(2);
    checks++;
    if (mon_q.size() - base !== 8) begin
      errors++; $display("FAIL srcid_count got %0d want 8", mon_q.size() - base);
    end else begin
      for (int i = 0; i < 8; i++) begin
        checks++;
        if (mon_q[base+i].tid !== mon_q[base+i].src || mon_q[base+i].src !== (i / 2) % 2) begin
          errors++;
          $display("FAIL srcid_beat%0d got tid=%0d src=%0d want %0d", i, mon_q[base+i].tid,
                   mon_q[base+i].src, (i / 2) % 2);
        end
      end
    end
  endtask
`endif

  initial begin
    for (int s = 0; s < 2; s++) begin
      src_valid[s] = 1'b0;
      src_last[s]  = 1'b0;
      src_data[s]  = '0;
      src_keep[s]  = '0;
    end
    m_tready = 1'b0;
    bp_done  = 1'b0;
    test_reset();
    test_single_source();
    test_contention();
    test_backpressure();
    test_mid_reset();
`ifdef AXIS_ARB_SRCID_EN
    test_srcid();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
